seven_seg_scan: RTL

//   Time-multiplexed scanner for an 8-digit common-anode seven-segment display.

---
 rtl/seven_seg_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scanner for a common-anode seven-segment display with
// frame-synchronous value updates, leading-zero blanking and anode guard time.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    input  logic        lz_en,
    output logic [3:0]  bcd,
    output logic [7:0]  an,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM     = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] PRE_TERM = CW'(REFRESH_DIV - 2);
    localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);
    localparam logic [2:0]    LAST     = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [31:0]   shadow_val_r;
    logic [7:0]    shadow_dp_r;
    logic [31:0]   active_val_r;
    logic [7:0]    active_dp_r;
    logic          pending_r;
    logic [3:0]    bcd_r;
    logic [7:0]    an_r;
    logic          dp_n_r;
    logic          frame_done_r;

    logic          slot_end_s;
    logic          frame_end_s;
    logic          frame_end_next_s;
    logic          blank_s;
    logic          lit_s;
    logic [3:0]    nibble_s;

    // Digit idx is a leading zero when it is not digit 0 and every nibble from
    // idx up to the top scanned digit is zero.
    function automatic logic lead_blank_f(input logic [31:0] val, input logic [2:0] idx);
        logic higher_nz;
        higher_nz = 1'b0;
        for (int j = 0; j < 8; j++) begin
            higher_nz = higher_nz | ((j < NUM_DIGITS) && (j >= int'(idx)) &&
                                     (val[4*j +: 4] != 4'h0));
        end
        return (idx != 3'd0) && !higher_nz;
    endfunction

    // Slot and frame decode plus per-digit display qualification
    always_comb begin
        slot_end_s       = 1'b0;
        frame_end_s      = 1'b0;
        frame_end_next_s = 1'b0;
        blank_s          = 1'b0;
        lit_s            = 1'b0;
        nibble_s         = 4'h0;
        slot_end_s       = (cnt_r == TERM);
        frame_end_s      = slot_end_s && (idx_r == LAST);
        frame_end_next_s = (cnt_r == PRE_TERM) && (idx_r == LAST);
        nibble_s         = active_val_r[{idx_r, 2'b00} +: 4];
        if (lz_en) begin
            blank_s = lead_blank_f(active_val_r, idx_r);
        end else begin
            blank_s = 1'b0;
        end
        lit_s = (cnt_r >= GUARD) && !blank_s;
    end

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == LAST) ? 3'd0 : idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Shadow capture and commit to the active set only at frame boundaries;
    // a load landing on the boundary bypasses the shadow stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_r <= 32'h0;
            shadow_dp_r  <= 8'h00;
            active_val_r <= 32'h0;
            active_dp_r  <= 8'h00;
            pending_r    <= 1'b0;
        end else begin
            if (load) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp_mask;
            end else begin
                shadow_val_r <= shadow_val_r;
                shadow_dp_r  <= shadow_dp_r;
            end
            if (frame_end_s) begin
                pending_r <= 1'b0;
                if (load) begin
                    active_val_r <= value;
                    active_dp_r  <= dp_mask;
                end else if (pending_r) begin
                    active_val_r <= shadow_val_r;
                    active_dp_r  <= shadow_dp_r;
                end else begin
                    active_val_r <= active_val_r;
                    active_dp_r  <= active_dp_r;
                end
            end else begin
                pending_r <= pending_r | load;
            end
        end
    end

    // Registered display outputs; frame_done is predicted one cycle early so
    // it is high exactly while the counter sits on the frame's last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r        <= 4'h0;
            an_r         <= 8'hFF;
            dp_n_r       <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            bcd_r        <= nibble_s;
            an_r         <= lit_s ? ~(8'h01 << idx_r) : 8'hFF;
            dp_n_r       <= lit_s ? ~active_dp_r[idx_r] : 1'b1;
            frame_done_r <= frame_end_next_s;
        end
    end

    assign bcd        = bcd_r;
    assign an         = an_r;
    assign dp_n       = dp_n_r;
    assign frame_done = frame_done_r;

endmodule
